// File: rtl/ws2812_tx_pkg.sv
// Shared types and constants for the WS2812 serialiser.
// Contents: state encoding, pixel geometry, default 12 MHz timing, bit-order helper.
package ws2812_tx_pkg;

    localparam int BITS_PER_LED = 24;

    localparam int DEF_NUM_LEDS = 16;
    localparam int DEF_T_BIT    = 15;
    localparam int DEF_T0H      = 5;
    localparam int DEF_T1H      = 10;
    localparam int DEF_T_RESET  = 960;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Serial position 0..23 within a pixel -> bit index in the pixel word.
    // Each byte goes out MSB first, bytes in G, R, B order.
    function automatic logic [4:0] bit_index(input logic [4:0] pos);
        return {pos[4:3], ~pos[2:0]};
    endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// Producer <-> serialiser bundle for the WS2812 transmitter.
// Signals: framebuf/start (producer to serialiser), busy/done/dout (serialiser out).
interface ws2812_tx_if
    import ws2812_tx_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS
);

    logic [NUM_LEDS*BITS_PER_LED-1:0] framebuf;
    logic                             start;
    logic                             busy;
    logic                             done;
    logic                             dout;

    modport master (
        output framebuf,
        output start,
        input  busy,
        input  done,
        input  dout
    );

    modport slave (
        input  framebuf,
        input  start,
        output busy,
        output done,
        output dout
    );

endinterface

// File: rtl/ws2812_tx_bit_gen.sv
// One WS2812 bit cell: T_BIT cycles, high for T0H or T1H cycles, registered output.
// Ports: clk, rst, go (load bit_val, pulse starts next cycle), bit_val,
//        pulse (line level), last (final cycle of the current cell).
module ws2812_tx_bit_gen #(
    parameter int T_BIT = 15,
    parameter int T0H   = 5,
    parameter int T1H   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic pulse,
    output logic last
);

    localparam int CW = $clog2(T_BIT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] th;
    logic          active;

    assign cnt_nx = cnt + CW'(1);
    assign last   = active && (cnt == CW'(T_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            th     <= '0;
            active <= 1'b0;
            pulse  <= 1'b0;
        end else if (go) begin
            // T0H > 0, so every cell opens high.
            cnt    <= '0;
            th     <= bit_val ? CW'(T1H) : CW'(T0H);
            active <= 1'b1;
            pulse  <= 1'b1;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                pulse  <= 1'b0;
            end else begin
                cnt   <= cnt_nx;
                pulse <= (cnt_nx < th);
            end
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame serialiser: snapshots framebuf on start, shifts NUM_LEDS x 24 bits
// (G,R,B, MSB first) as NRZ pulses, then holds the line low for the latch gap.
// Ports: clk, rst (async, active high), bus (slave: framebuf, start, busy, done, dout).
module ws2812_tx
    import ws2812_tx_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic        clk,
    input  logic        rst,
    ws2812_tx_if.slave  bus
);

    localparam int FW = NUM_LEDS * BITS_PER_LED;
    localparam int IW = $clog2(FW);
    localparam int CW = $clog2(T_RESET);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    state_t        state;
    logic [CW-1:0] cycle;
    logic [4:0]    bpos;
    logic [PW-1:0] pix;
    logic [FW-1:0] shadow;
    logic          busy;
    logic          done;

    logic          go;
    logic          bit_val;
    logic          last;
    logic          pulse;
    logic          final_bit;
    logic [4:0]    bpos_nx;
    logic [PW-1:0] pix_nx;
    logic [IW-1:0] idx_nx;

    always_comb begin
        final_bit = (bpos == 5'd23) && (pix == PW'(NUM_LEDS - 1));
        bpos_nx   = (bpos == 5'd23) ? 5'd0 : bpos + 5'd1;
        pix_nx    = (bpos == 5'd23) ? pix + PW'(1) : pix;
        idx_nx    = IW'(pix_nx) * IW'(BITS_PER_LED) + IW'(bit_index(bpos_nx));
        go        = 1'b0;
        bit_val   = 1'b0;
        unique case (state)
            IDLE: begin
                // First bit comes straight from framebuf; shadow loads on the same edge.
                go      = bus.start;
                bit_val = bus.framebuf[IW'(bit_index(5'd0))];
            end
            SEND: begin
                go      = last && !final_bit;
                bit_val = shadow[idx_nx];
            end
            LATCH: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LATCH;
            cycle  <= '0;
            bpos   <= '0;
            pix    <= '0;
            shadow <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            // Registered, so raise it one cycle early to land on the final gap cycle.
            done <= (state == LATCH) && (cycle == CW'(T_RESET - 2));
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shadow <= bus.framebuf;
                        bpos   <= '0;
                        pix    <= '0;
                        cycle  <= '0;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (last) begin
                        if (final_bit) begin
                            cycle <= '0;
                            state <= LATCH;
                        end else begin
                            bpos <= bpos_nx;
                            pix  <= pix_nx;
                        end
                    end
                end
                LATCH: begin
                    if (cycle == CW'(T_RESET - 1)) begin
                        cycle <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cycle <= cycle + CW'(1);
                    end
                end
                default: state <= LATCH;
            endcase
        end
    end

    ws2812_tx_bit_gen #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_gen (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .bit_val (bit_val),
        .pulse   (pulse),
        .last    (last)
    );

    assign bus.dout = pulse;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
